// File: rtl/apu_pkg.sv
// Shared definitions for the APU frame sequencer: power states, register
// indices and the per-step strobe masks.
package apu_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_CLEAR = 2'd2
    } apu_state_t;

    localparam logic [4:0] NR52_IDX     = 5'h16;
    localparam logic [4:0] LAST_CLR_IDX = 5'h15;

    // Bit n set means the strobe fires when the sequencer lands on step n.
    localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

    function automatic logic step_hit(input logic [7:0] mask, input logic [2:0] step);
        return mask[step];
    endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 512 Hz step counter with length/sweep/envelope strobes,
// NR52 power control and the power-off register clear walk.
module apu_frame_sequencer
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_clk_en,
    input  logic       div_bit,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_write,
    output logic [4:0] ch_addr,
    output logic [7:0] ch_wdata,
    output logic       ch_write,
    output logic       clk256_en,
    output logic       clk128_en,
    output logic       clk64_en,
    output logic [2:0] frame_step,
    output logic       power_on,
    output logic       busy
);

    apu_state_t r_state;
    logic [2:0] r_frame_step;
    logic [4:0] r_clr_idx;
    logic       r_div_prev;

    logic       w_cpu_wr;
    logic       w_ch_range;
    logic       w_nr52_wr;
    logic       w_power_off;
    logic       w_power_up;
    logic       w_tick;
    logic       w_step_adv;
    logic [2:0] w_step_next;

    assign w_cpu_wr    = cpu_write & slow_clk_en;
    assign w_ch_range  = (cpu_addr < NR52_IDX);
    assign w_nr52_wr   = w_cpu_wr && (cpu_addr == NR52_IDX);
    assign w_power_off = (r_state == ST_ON)  && w_nr52_wr && !cpu_wdata[7];
    assign w_power_up  = (r_state == ST_OFF) && w_nr52_wr &&  cpu_wdata[7];
    assign w_tick      = slow_clk_en && r_div_prev && !div_bit;
    // A power-off in the same cycle as a tick suppresses the advance.
    assign w_step_adv  = (r_state == ST_ON) && w_tick && !w_power_off;
    assign w_step_next = r_frame_step + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_OFF;
            r_frame_step <= 3'd0;
            r_clr_idx    <= 5'd0;
            r_div_prev   <= 1'b0;
        end else begin
            if (slow_clk_en) begin
                r_div_prev <= div_bit;
            end
            case (r_state)
                ST_OFF: begin
                    if (w_power_up) begin
                        r_state      <= ST_ON;
                        r_frame_step <= 3'd7;
                    end
                end
                ST_ON: begin
                    if (w_power_off) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= 5'd0;
                    end else if (w_step_adv) begin
                        r_frame_step <= w_step_next;
                    end
                end
                ST_CLEAR: begin
                    if (slow_clk_en) begin
                        if (r_clr_idx == LAST_CLR_IDX) begin
                            r_state   <= ST_OFF;
                            r_clr_idx <= 5'd0;
                        end else begin
                            r_clr_idx <= r_clr_idx + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    // Strobes reflect the step being entered, in the tick cycle itself.
    assign clk256_en = w_step_adv && step_hit(LEN_STEP_MASK,   w_step_next);
    assign clk128_en = w_step_adv && step_hit(SWEEP_STEP_MASK, w_step_next);
    assign clk64_en  = w_step_adv && step_hit(ENV_STEP_MASK,   w_step_next);

    always_comb begin
        ch_addr  = cpu_addr;
        ch_wdata = cpu_wdata;
        ch_write = 1'b0;
        if (r_state == ST_CLEAR) begin
            ch_addr  = r_clr_idx;
            ch_wdata = 8'h00;
            ch_write = slow_clk_en;
        end else if (r_state == ST_ON) begin
            ch_write = w_cpu_wr && w_ch_range;
        end
    end

    assign frame_step = r_frame_step;
    assign power_on   = (r_state == ST_ON);
    assign busy       = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed self-checking bench for apu_frame_sequencer.
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       slow_clk_en;
    logic       div_bit;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_write;
    logic [4:0] ch_addr;
    logic [7:0] ch_wdata;
    logic       ch_write;
    logic       clk256_en;
    logic       clk128_en;
    logic       clk64_en;
    logic [2:0] frame_step;
    logic       power_on;
    logic       busy;

    int errors = 0;
    int checks = 0;

    apu_frame_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .slow_clk_en(slow_clk_en),
        .div_bit    (div_bit),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_write   (ch_write),
        .clk256_en  (clk256_en),
        .clk128_en  (clk128_en),
        .clk64_en   (clk64_en),
        .frame_step (frame_step),
        .power_on   (power_on),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic div, input logic wr,
                         input logic [4:0] a, input logic [7:0] d);
        slow_clk_en = en;
        div_bit     = div;
        cpu_write   = wr;
        cpu_addr    = a;
        cpu_wdata   = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 5'h16, 8'h80);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h80);
        @(negedge clk);
        checks++;
        if ({power_on, busy, frame_step} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got pwr=%b busy=%b step=%0d expected 0/0/0", power_on, busy, frame_step);
        end
        checks++;
        if ({ch_write, clk256_en, clk128_en, clk64_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: got wr/256/128/64=%b expected 0000",
                     {ch_write, clk256_en, clk128_en, clk64_en});
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        reset = 1'b1;
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_power_on();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h80);
        @(negedge clk);
        checks++;
        if (ch_write !== 1'b0) begin
            errors++;
            $display("FAIL nr52_not_forwarded: got ch_write=%b expected 0", ch_write);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        checks++;
        if ({power_on, busy, frame_step} !== {1'b1, 1'b0, 3'd7}) begin
            errors++;
            $display("FAIL power_on: got pwr=%b busy=%b step=%0d expected 1/0/7", power_on, busy, frame_step);
        end
        $display("test_power_on done");
    endtask

    task automatic test_frame_steps();
        logic [7:0] e256;
        logic [7:0] e128;
        logic [7:0] e64;
        e256 = 8'b0101_0101;
        e128 = 8'b0100_0100;
        e64  = 8'b1000_0000;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
            @(negedge clk);
            checks++;
            if ({clk256_en, clk128_en, clk64_en} !== 3'b000) begin
                errors++;
                $display("FAIL strobe_rise_%0d: got %b expected 000", k, {clk256_en, clk128_en, clk64_en});
            end
            next_cycle();
            drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
            @(negedge clk);
            checks++;
            if ({clk256_en, clk128_en, clk64_en} !== {e256[k], e128[k], e64[k]}) begin
                errors++;
                $display("FAIL strobe_tick_%0d: got %b expected %b", k,
                         {clk256_en, clk128_en, clk64_en}, {e256[k], e128[k], e64[k]});
            end
            next_cycle();
            checks++;
            if (frame_step !== k[2:0]) begin
                errors++;
                $display("FAIL step_%0d: got %0d expected %0d", k, frame_step, k);
            end
            @(negedge clk);
            checks++;
            if ({clk256_en, clk128_en, clk64_en} !== 3'b000) begin
                errors++;
                $display("FAIL strobe_width_%0d: got %b expected 000", k, {clk256_en, clk128_en, clk64_en});
            end
            next_cycle();
        end
        $display("test_frame_steps done");
    endtask

    task automatic test_forward();
        drive(1'b1, 1'b0, 1'b1, 5'h12, 8'hA5);
        @(negedge clk);
        checks++;
        if ({ch_write, ch_addr, ch_wdata} !== {1'b1, 5'h12, 8'hA5}) begin
            errors++;
            $display("FAIL forward: got w=%b a=%h d=%h expected 1/12/a5", ch_write, ch_addr, ch_wdata);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h17, 8'h5A);
        @(negedge clk);
        checks++;
        if (ch_write !== 1'b0) begin
            errors++;
            $display("FAIL out_of_range: got ch_write=%b expected 0", ch_write);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h80);
        @(negedge clk);
        checks++;
        if (ch_write !== 1'b0) begin
            errors++;
            $display("FAIL nr52_on_again: got ch_write=%b expected 0", ch_write);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        checks++;
        if ({power_on, busy, frame_step} !== {1'b1, 1'b0, 3'd7}) begin
            errors++;
            $display("FAIL nr52_noop: got pwr=%b busy=%b step=%0d expected 1/0/7", power_on, busy, frame_step);
        end
        $display("test_forward done");
    endtask

    task automatic test_tick_with_write();
        drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h05, 8'h3C);
        @(negedge clk);
        checks++;
        if ({ch_write, ch_addr, ch_wdata, clk256_en} !== {1'b1, 5'h05, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL tick_write: got w=%b a=%h d=%h s256=%b expected 1/05/3c/1",
                     ch_write, ch_addr, ch_wdata, clk256_en);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        checks++;
        if (frame_step !== 3'd0) begin
            errors++;
            $display("FAIL tick_write_step: got %0d expected 0", frame_step);
        end
        $display("test_tick_with_write done");
    endtask

    task automatic test_power_off_clear();
        drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h00);
        @(negedge clk);
        checks++;
        if ({clk256_en, clk128_en, clk64_en, ch_write} !== 4'b0000) begin
            errors++;
            $display("FAIL off_tick_strobe: got 256/128/64/wr=%b expected 0000",
                     {clk256_en, clk128_en, clk64_en, ch_write});
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        checks++;
        if ({busy, power_on, frame_step} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL enter_clear: got busy=%b pwr=%b step=%0d expected 1/0/0", busy, power_on, frame_step);
        end
        for (int i = 0; i < 22; i++) begin
            if (i == 5)
                drive(1'b1, 1'b0, 1'b1, 5'h03, 8'hFF);
            else if (i == 9)
                drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h80);
            else
                drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
            @(negedge clk);
            checks++;
            if ({busy, ch_write, ch_addr, ch_wdata} !== {1'b1, 1'b1, i[4:0], 8'h00}) begin
                errors++;
                $display("FAIL clear_%0d: got busy=%b w=%b a=%h d=%h expected 1/1/%h/00",
                         i, busy, ch_write, ch_addr, ch_wdata, i[4:0]);
            end
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        checks++;
        if ({busy, power_on, frame_step} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clear_done: got busy=%b pwr=%b step=%0d expected 0/0/0", busy, power_on, frame_step);
        end
        @(negedge clk);
        checks++;
        if (ch_write !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got ch_write=%b expected 0", ch_write);
        end
        next_cycle();
        $display("test_power_off_clear done");
    endtask

    task automatic test_off_behaviour();
        drive(1'b1, 1'b0, 1'b1, 5'h02, 8'h11);
        @(negedge clk);
        checks++;
        if (ch_write !== 1'b0) begin
            errors++;
            $display("FAIL off_drop: got ch_write=%b expected 0", ch_write);
        end
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        @(negedge clk);
        checks++;
        if ({clk256_en, clk128_en, clk64_en} !== 3'b000) begin
            errors++;
            $display("FAIL off_tick: got %b expected 000", {clk256_en, clk128_en, clk64_en});
        end
        next_cycle();
        checks++;
        if ({power_on, frame_step} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL off_hold: got pwr=%b step=%0d expected 0/0", power_on, frame_step);
        end
        $display("test_off_behaviour done");
    endtask

    task automatic test_power_up_first_tick();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h80);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
        checks++;
        if ({power_on, frame_step} !== {1'b1, 3'd7}) begin
            errors++;
            $display("FAIL repower: got pwr=%b step=%0d expected 1/7", power_on, frame_step);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        @(negedge clk);
        checks++;
        if ({clk256_en, clk128_en, clk64_en} !== 3'b100) begin
            errors++;
            $display("FAIL first_tick: got %b expected 100", {clk256_en, clk128_en, clk64_en});
        end
        next_cycle();
        checks++;
        if (frame_step !== 3'd0) begin
            errors++;
            $display("FAIL first_step: got %0d expected 0", frame_step);
        end
        $display("test_power_up_first_tick done");
    endtask

    task automatic test_slow_en();
        drive(1'b1, 1'b1, 1'b0, 5'h00, 8'h00);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 5'h04, 8'h77);
        @(negedge clk);
        checks++;
        if ({clk256_en, clk128_en, clk64_en, ch_write} !== 4'b0000) begin
            errors++;
            $display("FAIL en_low: got 256/128/64/wr=%b expected 0000",
                     {clk256_en, clk128_en, clk64_en, ch_write});
        end
        next_cycle();
        checks++;
        if (frame_step !== 3'd0) begin
            errors++;
            $display("FAIL en_low_step: got %0d expected 0", frame_step);
        end
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        next_cycle();
        checks++;
        if (frame_step !== 3'd1) begin
            errors++;
            $display("FAIL en_high_step: got %0d expected 1", frame_step);
        end
        $display("test_slow_en done");
    endtask

    task automatic test_reset_mid_clear();
        drive(1'b1, 1'b0, 1'b1, 5'h16, 8'h00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        checks++;
        if ({ch_write, ch_addr} !== {1'b1, 5'h0A}) begin
            errors++;
            $display("FAIL pre_abort: got w=%b a=%h expected 1/0a", ch_write, ch_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ch_write, busy, power_on, frame_step} !== 6'b0) begin
            errors++;
            $display("FAIL abort: got w=%b busy=%b pwr=%b step=%0d expected 0/0/0/0",
                     ch_write, busy, power_on, frame_step);
        end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ch_write, busy} !== 2'b00) begin
                errors++;
                $display("FAIL post_abort_%0d: got w=%b busy=%b expected 0/0", i, ch_write, busy);
            end
            next_cycle();
        end
        $display("test_reset_mid_clear done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_on();
        test_frame_steps();
        test_forward();
        test_tick_with_write();
        test_power_off_clear();
        test_off_behaviour();
        test_power_up_first_tick();
        test_slow_en();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: reset  input  1  asynchronous active-low reset.
REQ-004 Port: slow_clk_en  input  1  APU-rate enable; all state advances only in cycles where it is high.
REQ-005 Port: div_bit  input  1  timer DIV tap; each falling edge is one 512 Hz frame tick.
REQ-006 Port: cpu_addr  input  5  APU register index, 0x00=NR10 .. 0x16=NR52.
REQ-007 Port: cpu_wdata  input  8  CPU write data.
REQ-008 Port: cpu_write  input  1  CPU write strobe, one slow_clk_en cycle.
REQ-009 Port: ch_addr, ch_wdata, ch_write  output  5/8/1  write bus to channel register files.
REQ-010 Port: clk256_en, clk128_en, clk64_en  output  1 each  length, sweep and envelope strobes.
REQ-011 Port: frame_step  output  3  current sequencer step.
REQ-012 Port: power_on  output  1  NR52 bit 7 as seen by the CPU.
REQ-013 Port: busy  output  1  high while a power-off clear is in progress.

Function
REQ-014 States SHALL be OFF, ON and CLEAR; power_on=1 only in ON; busy=1 only in CLEAR.
REQ-015 Frame tick: falling edge of div_bit, sampled on slow_clk_en (div_bit prev=1, now=0); the sample register SHALL update in every slow_clk_en cycle, in every state.
REQ-016 In ON, each tick SHALL increment frame_step mod 8 (7->0 wraps) in that cycle.
REQ-017 In the tick cycle, with the new step: clk256_en=1 for step 0,2,4,6; clk128_en=1 for 2,6; clk64_en=1 for 7; each strobe is exactly one clk cycle wide.
REQ-018 In OFF and CLEAR, ticks SHALL be ignored, frame_step SHALL hold, and all strobes SHALL be 0.
REQ-019 In ON, a cpu_write to index 0x00-0x15 SHALL be forwarded combinationally in the same cycle: ch_addr=cpu_addr, ch_wdata=cpu_wdata, ch_write=1.
REQ-020 Writes to index 0x16 and to index >0x16 SHALL never drive ch_write.
REQ-021 In OFF and CLEAR, CPU writes to 0x00-0x15 SHALL be dropped.
REQ-022 In ON, a write to 0x16 with bit 7=0 SHALL move to CLEAR and load the clear index to 0x00.
REQ-023 In CLEAR, each slow_clk_en cycle SHALL issue ch_write=1 with ch_addr=index and ch_wdata=0x00, then increment the index.
REQ-024 After the write to index 0x15 (22 writes total), CLEAR SHALL move to OFF.
REQ-025 In OFF, a write to 0x16 with bit 7=1 SHALL move to ON and set frame_step=7, so the first tick yields step 0 and a clk256_en pulse.
REQ-026 In CLEAR, all NR52 writes SHALL be ignored; an NR52 write that does not change the power state SHALL have no effect.
REQ-027 If a power-off write and a tick fall in the same cycle, power-off SHALL win: no strobe and frame_step held.
REQ-028 A same-cycle CPU write to 0x00-0x15 during a tick in ON SHALL still be forwarded.

Reset
REQ-029 Asserting reset SHALL immediately set state=OFF, frame_step=0, clear index=0 and div sample=0, and drive all strobes and ch_write to 0.
REQ-030 Reset asserted during CLEAR SHALL abort the clear sequence; no further ch_write SHALL occur.

Structure
REQ-031 Shared package apu_pkg SHALL hold the state enum, NR52_IDX=5'h16, LAST_CLR_IDX=5'h15, and the step masks for the length, sweep and envelope strobes.
REQ-032 The block SHALL be a single module with no sub-module; the edge detector and the clear counter are inline.

Verification
REQ-033 Reset, write 0x80 to 0x16, then 8 div_bit falling edges -> frame_step 0..7; clk256_en at 0,2,4,6; clk128_en at 2,6; clk64_en at 7.
REQ-034 In ON, write 0xA5 to 0x12 -> ch_write=1, ch_addr=0x12, ch_wdata=0xA5 in the same cycle.
REQ-035 Write 0x00 to 0x16 -> busy=1 for 22 slow_clk_en cycles with ch_addr 0x00..0x15 and data 0x00, then OFF; a CPU write to 0x03 mid-clear is not forwarded.
REQ-036 Power-off write coincident with a div falling edge -> no strobe, frame_step unchanged, CLEAR entered.
REQ-037 Reset asserted at clear index 0x0A -> ch_write=0 immediately, state OFF, frame_step 0.
REQ-038 In OFF, write 0x80 to 0x16 -> the next falling edge gives frame_step=0 with clk256_en=1.
